// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and reader state encoding.
// Both the burst reader and the frame-buffer writer import this package.
package fb_pkg;
    localparam int FRAME_WIDTH  = 1920;
    localparam int FRAME_HEIGHT = 1080;
    localparam int FRAME_WORDS  = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int ADDR_W       = 27;
    localparam int DATA_W       = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/fb_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module fb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
        // DEPTH is a power of two, so pointer roll-over is the wrap.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
endmodule

// File: rtl/fb_burst_reader.sv
// Reads one frame from DDR in fixed-length Avalon bursts and streams pixels out.
// Bursts are only issued when the FIFO has room for every word already in flight.
module fb_burst_reader #(
    parameter int ADDR_W      = fb_pkg::ADDR_W,
    parameter int DATA_W      = fb_pkg::DATA_W,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_WORDS = fb_pkg::FRAME_WORDS
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_burstbegin,
    output logic [3:0]        avl_size,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic [23:0]       oPIX_DATA,
    output logic              oPIX_VALID,
    input  logic              iPIX_READY,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic              oOVERFLOW
);
    import fb_pkg::*;

    localparam int NUM_BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int BIDX_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [BIDX_W-1:0] burst_q, burst_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    logic              rdv_live, pop, issue;
    logic              unused_hi;

    // Returns still in flight after a reset are ignored until the next frame starts.
    assign rdv_live  = avl_readdatavalid && (state_q != ST_IDLE);
    assign pop       = iPIX_READY && !fifo_empty;
    assign issue     = (state_q == ST_REQ) && avl_waitrequest_n;
    assign unused_hi = ^fifo_rdata[DATA_W-1:24];

    fb_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .wr_en   (rdv_live),
        .wr_data (avl_readdata),
        .rd_en   (iPIX_READY),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        ovf_d   = ovf_q || (rdv_live && fifo_full && !pop);
        // A stray return with nothing outstanding must not wrap the counter.
        outst_d = outst_q + (issue ? CNT_W'(BURST_LEN) : '0)
                          - ((rdv_live && (outst_q != '0)) ? CNT_W'(1) : '0);
        case (state_q)
            ST_IDLE: begin
                addr_d  = '0;
                burst_d = '0;
                outst_d = '0;
                if (iSTART && local_init_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (int'(fifo_count) + int'(outst_q) + BURST_LEN <= FIFO_DEPTH)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (issue) begin
                    if (burst_q == BIDX_W'(NUM_BURSTS - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(BURST_LEN);
                        burst_d = burst_q + BIDX_W'(1);
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            outst_q <= '0;
            burst_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            burst_q <= burst_d;
            ovf_q   <= ovf_d;
        end
    end

    assign avl_read       = (state_q == ST_REQ);
    assign avl_burstbegin = avl_read;
    assign avl_address    = addr_q;
    assign avl_size       = 4'(BURST_LEN);
    assign oPIX_VALID     = !fifo_empty;
    assign oPIX_DATA      = fifo_empty ? 24'd0 : fifo_rdata[23:0];
    assign oBUSY          = (state_q != ST_IDLE);
    assign oFRAME_DONE    = (state_q == ST_DONE);
    assign oOVERFLOW      = ovf_q;
endmodule

// File: doc/fb_burst_reader.md
FB_BURST_READER -- requirements
Module: fb_burst_reader

Interface
REQ-001 Parameter ADDR_W, default 27, Avalon word-address width.
REQ-002 Parameter DATA_W, default 32, Avalon data width.
REQ-003 Parameter BURST_LEN, default 8, words per read burst.
REQ-004 Parameter FIFO_DEPTH, default 64, pixel FIFO depth in words; power of two and >= 2*BURST_LEN.
REQ-005 Parameter FRAME_WORDS, default 2073600 (1920*1080), words per frame; multiple of BURST_LEN.
REQ-006 Port iCLK, input, 1, single clock for all logic.
REQ-007 Port iRST_n, input, 1, asynchronous active-low reset.
REQ-008 Port iSTART, input, 1, single-cycle frame-read request.
REQ-009 Port local_init_done, input, 1, DDR controller calibration complete.
REQ-010 Port avl_waitrequest_n, input, 1, controller accepts the current command.
REQ-011 Port avl_address, output, ADDR_W, burst start word address.
REQ-012 Port avl_read, output, 1, read command.
REQ-013 Port avl_burstbegin, output, 1, equal to avl_read.
REQ-014 Port avl_size, output, 4, constant BURST_LEN.
REQ-015 Port avl_readdatavalid, input, 1, return word valid.
REQ-016 Port avl_readdata, input, DATA_W, return word.
REQ-017 Port oPIX_DATA, output, 24, pixel {R,G,B} = word[23:0].
REQ-018 Port oPIX_VALID, output, 1, pixel available.
REQ-019 Port iPIX_READY, input, 1, consumer accepts pixel when oPIX_VALID is high.
REQ-020 Port oBUSY, output, 1, high in every state except IDLE.
REQ-021 Port oFRAME_DONE, output, 1, one-cycle pulse after the last pixel is accepted.
REQ-022 Port oOVERFLOW, output, 1, sticky error: return word arrived while FIFO full.

Function
REQ-023 States SHALL be IDLE, CHECK, REQ, DRAIN and DONE.
REQ-024 IDLE: avl_address=0, counters cleared; go to CHECK when iSTART && local_init_done; iSTART is ignored in every other state.
REQ-025 CHECK: go to REQ when fifo_count + outstanding + BURST_LEN <= FIFO_DEPTH; otherwise remain.
REQ-026 REQ: assert avl_read and hold address until a cycle with avl_waitrequest_n=1; in that cycle add BURST_LEN to outstanding, then go to DRAIN if this was burst FRAME_WORDS/BURST_LEN-1, else add BURST_LEN to avl_address and go to CHECK.
REQ-027 Each avl_readdatavalid cycle SHALL write avl_readdata into the FIFO and decrement outstanding by 1; simultaneous issue and return net to +BURST_LEN-1.
REQ-028 DRAIN: go to DONE when outstanding==0 and the FIFO is empty and no pixel is pending on the output.
REQ-029 DONE: assert oFRAME_DONE for exactly one cycle, then go to IDLE.
REQ-030 FIFO SHALL be show-ahead: a word written into an empty FIFO appears on oPIX_DATA with oPIX_VALID=1 on the next cycle.
REQ-031 A pixel pops on every cycle with oPIX_VALID && iPIX_READY; oPIX_DATA and oPIX_VALID SHALL hold stable while iPIX_READY=0.
REQ-032 FIFO write and read in the same cycle SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-033 A return word while full SHALL be dropped and SHALL set oOVERFLOW until reset.
REQ-034 Counters SHALL be sized to hold 0..FIFO_DEPTH (outstanding, count) and 0..FRAME_WORDS/BURST_LEN-1 (burst index) without overflow.

Reset
REQ-035 Reset SHALL drive state=IDLE, avl_read=0, avl_address=0, outstanding=0, FIFO empty, oPIX_VALID=0, oPIX_DATA=0, oBUSY=0, oFRAME_DONE=0 and oOVERFLOW=0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately; in-flight returns after reset release are discarded while in IDLE.

Structure
REQ-037 Shared package fb_pkg SHALL hold FRAME_WIDTH=1920, FRAME_HEIGHT=1080, FRAME_WORDS, ADDR_W, DATA_W and the state encoding; the frame-buffer writer uses the same package.
REQ-038 FIFO SHALL be a sub-module fb_sync_fifo (show-ahead, count output); all other logic stays in fb_burst_reader.

Verification
REQ-039 Start with local_init_done=0 -> no avl_read; raise it and pulse iSTART -> first avl_read at address 0, avl_size=8.
REQ-040 Memory model returns address as data, iPIX_READY=1, waitrequest_n randomly low -> 2073600 pixels in order, addresses 0,8,16,...,2073592; oFRAME_DONE pulses once, after the last pixel is accepted.
REQ-041 iPIX_READY=0 for 500 cycles -> exactly 8 bursts issued (64 words), no further avl_read, oOVERFLOW=0; releasing iPIX_READY resumes requests.
REQ-042 Simultaneous readdatavalid and pixel pop at FIFO count 64 -> count stays 64, no data lost.
REQ-043 iRST_n low at pixel 1000 -> all outputs at reset values; new iSTART reads again from address 0.
REQ-044 Inject an extra readdatavalid while FIFO is full -> oOVERFLOW=1 and stays high until reset.
